// File: rtl/rgb_pkg.sv
// Shared palette, widths and FSM encoding for the RGB colour blocks.
// Palette contents match the colour converter's init data.
package rgb_pkg;

    localparam int CODE_W = 3;
    localparam int RGB_W  = 24;
    localparam int DIST_W = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Element k of the packed array is the RGB value of code k.
    localparam logic [7:0][RGB_W-1:0] PALETTE = {
        24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
        24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000
    };

    function automatic logic [7:0] abs_diff(
        input logic [7:0] a,
        input logic [7:0] b
    );
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [DIST_W-1:0] l1_dist(
        input logic [RGB_W-1:0] a,
        input logic [RGB_W-1:0] b
    );
        logic [7:0] dr;
        logic [7:0] dg;
        logic [7:0] db;
        dr = abs_diff(a[23:16], b[23:16]);
        dg = abs_diff(a[15:8], b[15:8]);
        db = abs_diff(a[7:0], b[7:0]);
        return {2'b00, dr} + {2'b00, dg} + {2'b00, db};
    endfunction

endpackage

// File: rtl/palette_rom.sv
// 8-entry palette ROM with a one-cycle registered read.
// Output register clears on reset, matching the converter's BRAM timing.
module palette_rom
    import rgb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] addr,
    output logic [RGB_W-1:0]  data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= PALETTE[addr];
        end
    end

endmodule

// File: rtl/rgb_quantiser.sv
// Maps a 24-bit RGB value to the nearest palette code by sequential L1 scan.
// Define RGB_QUANT_EARLY_EXIT_EN to abort the scan on an exact match.
module rgb_quantiser
    import rgb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RGB_W-1:0]  rgb_in,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] colour,
    output logic [DIST_W-1:0] distance
);

    logic [1:0]        state;
    logic [CODE_W-1:0] addr;
    logic [CODE_W-1:0] rd_addr;
    logic              rd_valid;
    logic [RGB_W-1:0]  pix;
    logic [RGB_W-1:0]  rom_data;
    logic [DIST_W-1:0] best_dist;
    logic [CODE_W-1:0] best_code;

    logic [DIST_W-1:0] cur_dist;
    logic [DIST_W-1:0] nxt_dist;
    logic [CODE_W-1:0] nxt_code;
    logic              take;
    logic              hit;
    logic              finish;
    logic              accept;

    palette_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .data  (rom_data)
    );

    always_comb begin
        cur_dist = l1_dist(pix, rom_data);
        take     = rd_valid && (cur_dist < best_dist);
        nxt_dist = take ? cur_dist : best_dist;
        nxt_code = take ? rd_addr : best_code;
`ifdef RGB_QUANT_EARLY_EXIT_EN
        hit      = rd_valid && (cur_dist == '0);
`else
        hit      = 1'b0;
`endif
        finish   = (state == ST_FLUSH) || hit;
        // The finishing cycle may also accept the next request.
        accept   = start && ((state == ST_IDLE) || finish);
    end

    // A chained request is hidden during the result cycle.
    assign busy = (state != ST_IDLE) && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            pix       <= '0;
            best_dist <= '1;
            best_code <= '0;
            done      <= 1'b0;
            colour    <= '0;
            distance  <= '0;
        end else begin
            rd_valid <= (state == ST_SCAN) && !finish;
            rd_addr  <= addr;
            done     <= finish;
            if (rd_valid) begin
                best_dist <= nxt_dist;
                best_code <= nxt_code;
            end
            if (finish) begin
                colour   <= nxt_code;
                distance <= nxt_dist;
            end
            if (accept) begin
                state     <= ST_SCAN;
                addr      <= '0;
                pix       <= rgb_in;
                best_dist <= '1;
                best_code <= '0;
            end else if (finish) begin
                state <= ST_IDLE;
            end else if (state == ST_SCAN) begin
                addr <= addr + 3'd1;
                if (addr == 3'd7) begin
                    state <= ST_FLUSH;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_quantiser.sv
// Directed self-checking bench for rgb_quantiser.
// Expected latencies follow RGB_QUANT_EARLY_EXIT_EN when it is defined.
module tb_rgb_quantiser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] rgb_in = '0;
    logic        busy;
    logic        done;
    logic [2:0]  colour;
    logic [9:0]  distance;

    int checks = 0;
    int failures = 0;
    int lat;

`ifdef RGB_QUANT_EARLY_EXIT_EN
    localparam int LAT_C0 = 2;
    localparam int LAT_C1 = 3;
`else
    localparam int LAT_C0 = 9;
    localparam int LAT_C1 = 9;
`endif

    rgb_quantiser dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rgb_in   (rgb_in),
        .busy     (busy),
        .done     (done),
        .colour   (colour),
        .distance (distance)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            check("no_overlap", {31'd0, busy & done}, 0);
            if (done) return;
        end
        check("timeout", {31'd0, done}, 1);
    endtask

    task automatic run(
        input string       tag,
        input logic [23:0] rgb,
        input logic [2:0]  c,
        input logic [9:0]  d,
        input int          lat_exp
    );
        int n;
        @(negedge clk);
        start  = 1'b1;
        rgb_in = rgb;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, {31'd0, busy}, 1);
        @(negedge clk);
        start  = 1'b0;
        rgb_in = $urandom;
        wait_done(n);
        check({tag, "_lat"}, n, lat_exp);
        check({tag, "_col"}, {29'd0, colour}, {29'd0, c});
        check({tag, "_dist"}, {22'd0, distance}, {22'd0, d});
    endtask

    initial begin
        #22;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_col", {29'd0, colour}, 0);
        check("rst_dist", {22'd0, distance}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("white", 24'hFFFFFF, 3'd7, 10'd0, 9);
        run("black", 24'h000000, 3'd0, 10'd0, LAT_C0);
        run("brown", 24'h804020, 3'd4, 10'd223, 9);
        run("teal", 24'h10F0E0, 3'd3, 10'd62, 9);

        // Start pulses at E3 (ignored) and E8->E9 (chained).
        @(negedge clk);
        start  = 1'b1;
        rgb_in = 24'h804020;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (e < 9) begin
                check("hold_col", {29'd0, colour}, 3);
                check("hold_dist", {22'd0, distance}, 62);
                check("hold_done", {31'd0, done}, 0);
            end
            if (e == 2 || e == 8) begin
                @(negedge clk);
                start  = 1'b1;
                rgb_in = 24'h0000FF;
            end else if (e == 3) begin
                @(negedge clk);
                start  = 1'b0;
                rgb_in = '0;
            end
        end
        check("bz_done", {31'd0, done}, 1);
        check("bz_busy", {31'd0, busy}, 0);
        check("bz_col", {29'd0, colour}, 4);
        check("bz_dist", {22'd0, distance}, 223);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("chain_lat", lat, LAT_C1);
        check("chain_col", {29'd0, colour}, 1);
        check("chain_dist", {22'd0, distance}, 0);

        // Back-to-back with start held high.
        @(negedge clk);
        start  = 1'b1;
        rgb_in = 24'h804020;
        @(posedge clk);
        #1;
        @(negedge clk);
        rgb_in = 24'h10F0E0;
        wait_done(lat);
        check("b2b0_lat", lat, 9);
        check("b2b0_col", {29'd0, colour}, 4);
        check("b2b0_dist", {22'd0, distance}, 223);
        @(negedge clk);
        rgb_in = 24'h123456;
        wait_done(lat);
        check("b2b1_lat", lat, 9);
        check("b2b1_col", {29'd0, colour}, 3);
        check("b2b1_dist", {22'd0, distance}, 62);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("b2b2_lat", lat, 9);
        check("b2b2_col", {29'd0, colour}, 0);
        check("b2b2_dist", {22'd0, distance}, 156);

        run("pre_rst", 24'h804020, 3'd4, 10'd223, 9);

        // Reset at E4 of a scan.
        @(negedge clk);
        start  = 1'b1;
        rgb_in = 24'hFFFFFF;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 0);
        check("mid_done", {31'd0, done}, 0);
        check("mid_col", {29'd0, colour}, 0);
        check("mid_dist", {22'd0, distance}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("no_done", {31'd0, done | busy}, 0);
        end
        run("post_rst", 24'h0000FF, 3'd1, 10'd0, LAT_C1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
